// File: rtl/song_recorder.sv
// Live key-press recorder: quantizes held durations and rests into a track RAM.
// Optional metronome click is built when REC_METRONOME_EN is defined.
module song_recorder #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 10,
    parameter int REST_MIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              tick,
    input  logic [7:0]        full_note,
    input  logic [6:0]        note_key,
    input  logic [2:0]        octave,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        rd_octave,
    output logic [2:0]        rd_note,
    output logic [2:0]        rd_length,
    output logic [ADDR_W:0]   track,
    output logic              recording,
    output logic              full,
    output logic              overflow,
    output logic              click
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int CW = (DUR_W > 10) ? DUR_W : 10;
    localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [DUR_W-1:0] LP_REST  = DUR_W'(REST_MIN);

    state_t             r_state;
    state_t             w_state_n;
    logic [DUR_W-1:0]   r_dur;
    logic [DUR_W-1:0]   w_dur_n;
    logic [DUR_W-1:0]   w_dur_inc;
    logic [DUR_W-1:0]   w_dur_start;
    logic [2:0]         r_note;
    logic [2:0]         r_oct;
    logic [ADDR_W:0]    r_track;
    logic               r_ovf;
    logic [8:0]         r_rd;
    logic [8:0]         r_mem [DEPTH];

    logic [2:0]         w_key;
    logic [2:0]         w_code;
    logic [CW-1:0]      w_fn3;
    logic [CW-1:0]      w_dur_x;
    logic               w_commit;
    logic [8:0]         w_cdata;
    logic               w_cap;
    logic               w_clr;
    logic               w_full;
    logic               w_wr;

    // Lowest set key wins on multi-hot input.
    always_comb begin
        w_key = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (note_key[i]) begin
                w_key = 3'(i + 1);
            end
        end
    end

    assign w_fn3   = CW'({2'b00, full_note} * 10'd3);
    assign w_dur_x = CW'(r_dur);

    always_comb begin
        if (w_dur_x >= (w_fn3 >> 2)) begin
            w_code = 3'd0;
        end else if (w_dur_x >= (w_fn3 >> 3)) begin
            w_code = 3'd1;
        end else if (w_dur_x >= (w_fn3 >> 4)) begin
            w_code = 3'd2;
        end else if (w_dur_x >= (w_fn3 >> 5)) begin
            w_code = 3'd3;
        end else begin
            w_code = 3'd4;
        end
    end

    assign w_dur_inc   = (&r_dur) ? r_dur : r_dur + 1'b1;
    assign w_dur_start = tick ? DUR_W'(1) : '0;
    assign w_full      = (r_track == LP_DEPTH);

    always_comb begin
        w_state_n = r_state;
        w_dur_n   = r_dur;
        w_commit  = 1'b0;
        w_cdata   = {3'd0, 3'd0, w_code};
        w_cap     = 1'b0;
        w_clr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_dur_n = '0;
                if (en) begin
                    w_state_n = S_ARMED;
                end else if (clr) begin
                    w_clr = 1'b1;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    w_state_n = S_IDLE;
                end else if (w_key != 3'd0) begin
                    w_cap     = 1'b1;
                    w_dur_n   = '0;
                    w_state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                w_cdata = {r_oct, r_note, w_code};
                if (!en) begin
                    w_commit  = 1'b1;
                    w_dur_n   = '0;
                    w_state_n = S_IDLE;
                end else if (w_key == 3'd0) begin
                    w_commit  = 1'b1;
                    w_dur_n   = w_dur_start;
                    w_state_n = S_GAP;
                end else if (w_key != r_note) begin
                    w_commit = 1'b1;
                    w_cap    = 1'b1;
                    w_dur_n  = w_dur_start;
                end else if (tick) begin
                    w_dur_n = w_dur_inc;
                end
            end
            S_GAP: begin
                if (!en) begin
                    w_dur_n   = '0;
                    w_state_n = S_IDLE;
                end else if (w_key != 3'd0) begin
                    // Short gaps are articulation, not rests.
                    w_commit  = (r_dur >= LP_REST);
                    w_cap     = 1'b1;
                    w_dur_n   = w_dur_start;
                    w_state_n = S_HOLD;
                end else if (tick) begin
                    w_dur_n = w_dur_inc;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign w_wr = w_commit & ~w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dur   <= '0;
            r_note  <= 3'd0;
            r_oct   <= 3'd0;
            r_track <= '0;
            r_ovf   <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_n;
            r_dur   <= w_dur_n;
            if (w_cap) begin
                r_note <= w_key;
                r_oct  <= octave;
            end
            if (w_clr) begin
                r_track <= '0;
                r_ovf   <= 1'b0;
            end else if (w_commit) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_track <= r_track + 1'b1;
                end
            end
            if ({1'b0, rd_addr} < r_track) begin
                r_rd <= r_mem[rd_addr];
            end else begin
                r_rd <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_track[ADDR_W-1:0]] <= w_cdata;
        end
    end

    assign rd_octave = r_rd[8:6];
    assign rd_note   = r_rd[5:3];
    assign rd_length = r_rd[2:0];
    assign track     = r_track;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign recording = (r_state != S_IDLE);

`ifdef REC_METRONOME_EN
    logic [7:0] r_met;
    logic [7:0] w_per;
    logic       w_wrap;

    assign w_per  = (full_note[7:2] == 6'd0) ? 8'd1 : {2'b00, full_note[7:2]};
    assign w_wrap = (r_met >= w_per - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_met <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_met <= 8'd0;
        end else if (tick) begin
            r_met <= w_wrap ? 8'd0 : r_met + 8'd1;
        end
    end

    assign click = recording & tick & w_wrap;
`else
    assign click = 1'b0;
`endif

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: stimulus queues expectations,
// a monitor compares them when the requested response appears.
module tb_song_recorder;

    localparam int K_RD  = 0;
    localparam int K_ST  = 1;
    localparam int K_RD4 = 2;
    localparam int K_ST4 = 3;

    typedef struct {
        int          kind;
        int          tag;
        logic [15:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       tick;
    logic [7:0] full_note;
    logic [6:0] note_key;
    logic [2:0] octave;
    logic [5:0] rd_addr;
    logic [1:0] rd_addr4;

    logic [2:0] rd_octave, rd_note, rd_length;
    logic [6:0] track;
    logic       recording, full, overflow, click;

    logic [2:0] rd_octave4, rd_note4, rd_length4;
    logic [2:0] track4;
    logic       recording4, full4, overflow4, click4;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic req = 1'b0;
    logic r_pend = 1'b0;

    song_recorder u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick),
        .full_note(full_note), .note_key(note_key), .octave(octave),
        .rd_addr(rd_addr), .rd_octave(rd_octave), .rd_note(rd_note),
        .rd_length(rd_length), .track(track), .recording(recording),
        .full(full), .overflow(overflow), .click(click)
    );

    song_recorder #(.DEPTH(4), .ADDR_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .tick(tick),
        .full_note(full_note), .note_key(note_key), .octave(octave),
        .rd_addr(rd_addr4), .rd_octave(rd_octave4), .rd_note(rd_note4),
        .rd_length(rd_length4), .track(track4), .recording(recording4),
        .full(full4), .overflow(overflow4), .click(click4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag,
                       input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s#%0d act=%h exp=%h", nm, tag, act, exp);
        end
    endtask

    always @(posedge clk) r_pend <= req;

    always @(negedge clk) begin
        exp_t e;
        if (r_pend) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard empty on response");
            end else begin
                e = q.pop_front();
                case (e.kind)
                    K_RD:  chk("rd", e.tag,
                               16'({rd_octave, rd_note, rd_length}), e.exp);
                    K_ST:  chk("st", e.tag,
                               16'({track, full, overflow, recording}), e.exp);
                    K_RD4: chk("rd4", e.tag,
                               16'({rd_octave4, rd_note4, rd_length4}), e.exp);
                    default: chk("st4", e.tag,
                               16'({track4, full4, overflow4, recording4}), e.exp);
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic press(input logic [6:0] k, input logic [2:0] o);
        note_key = k;
        octave   = o;
        cyc(1);
    endtask

    task automatic release_k();
        note_key = 7'd0;
        cyc(1);
    endtask

    task automatic start();
        en = 1'b1;
        cyc(1);
    endtask

    task automatic stop();
        en = 1'b0;
        cyc(1);
        note_key = 7'd0;
        cyc(1);
    endtask

    task automatic clear();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic issue(input int kind, input int tag, input logic [15:0] exp);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.exp  = exp;
        q.push_back(e);
        req = 1'b1;
        cyc(1);
        req = 1'b0;
    endtask

    task automatic rd_chk(input int tag, input logic [5:0] a,
                          input logic [2:0] o, input logic [2:0] n,
                          input logic [2:0] l);
        rd_addr = a;
        issue(K_RD, tag, 16'({o, n, l}));
    endtask

    task automatic rd4_chk(input int tag, input logic [1:0] a,
                           input logic [2:0] o, input logic [2:0] n,
                           input logic [2:0] l);
        rd_addr4 = a;
        issue(K_RD4, tag, 16'({o, n, l}));
    endtask

    task automatic st_chk(input int tag, input logic [6:0] t,
                          input logic f, input logic ov, input logic rc);
        issue(K_ST, tag, 16'({t, f, ov, rc}));
    endtask

    task automatic st4_chk(input int tag, input logic [2:0] t,
                           input logic f, input logic ov, input logic rc);
        issue(K_ST4, tag, 16'({t, f, ov, rc}));
    endtask

    task automatic click_window(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            #2;
            if (click === 1'b1) cnt++;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_idle;
        int c_rec;
        int exp_rec;
        rst       = 1'b1;
        en        = 1'b0;
        clr       = 1'b0;
        tick      = 1'b0;
        full_note = 8'd16;
        note_key  = 7'd0;
        octave    = 3'd0;
        rd_addr   = 6'd0;
        rd_addr4  = 2'd0;
        cyc(2);
        rst = 1'b0;

        // reset state
        st_chk(0, 7'd0, 1'b0, 1'b0, 1'b0);
        st4_chk(0, 3'd0, 1'b0, 1'b0, 1'b0);
        rd_chk(0, 6'd0, 3'd0, 3'd0, 3'd0);

        // single note, 8 ticks at full_note=16 -> code 1
        start();
        press(7'b0000100, 3'd4);
        ticks(8);
        release_k();
        stop();
        st_chk(1, 7'd1, 1'b0, 1'b0, 1'b0);
        rd_chk(1, 6'd0, 3'd4, 3'd3, 3'd1);

        // note, stored rest, note ended by en fall
        clear();
        start();
        press(7'b0000001, 3'd2);
        ticks(4);
        release_k();
        ticks(5);
        press(7'b0010000, 3'd2);
        ticks(12);
        stop();
        st_chk(2, 7'd3, 1'b0, 1'b0, 1'b0);
        rd_chk(20, 6'd0, 3'd2, 3'd1, 3'd2);
        rd_chk(21, 6'd1, 3'd0, 3'd0, 3'd2);
        rd_chk(22, 6'd2, 3'd2, 3'd5, 3'd0);
        rd_chk(23, 6'd3, 3'd0, 3'd0, 3'd0);

        // short gap discarded
        clear();
        start();
        press(7'b0000001, 3'd3);
        ticks(4);
        release_k();
        ticks(1);
        press(7'b0000010, 3'd3);
        ticks(1);
        stop();
        st_chk(3, 7'd2, 1'b0, 1'b0, 1'b0);
        rd_chk(30, 6'd0, 3'd3, 3'd1, 3'd2);
        rd_chk(31, 6'd1, 3'd3, 3'd2, 3'd3);
        rd_chk(32, 6'd2, 3'd0, 3'd0, 3'd0);

        // multi-hot press, then direct switch to bit3 with new octave
        clear();
        start();
        press(7'b1000001, 3'd1);
        ticks(2);
        press(7'b0001000, 3'd6);
        ticks(6);
        release_k();
        stop();
        st_chk(4, 7'd2, 1'b0, 1'b0, 1'b0);
        rd_chk(40, 6'd0, 3'd1, 3'd1, 3'd3);
        rd_chk(41, 6'd1, 3'd6, 3'd4, 3'd1);

        // five notes into the 4-deep instance
        clear();
        start();
        for (int i = 0; i < 5; i++) begin
            press(7'(1 << i), 3'd5);
            ticks(1);
            release_k();
        end
        stop();
        st_chk(5, 7'd5, 1'b0, 1'b0, 1'b0);
        st4_chk(5, 3'd4, 1'b1, 1'b1, 1'b0);
        rd_chk(50, 6'd4, 3'd5, 3'd5, 3'd3);
        rd4_chk(51, 2'd0, 3'd5, 3'd1, 3'd3);
        rd4_chk(52, 2'd3, 3'd5, 3'd4, 3'd3);
        clear();
        st_chk(6, 7'd0, 1'b0, 1'b0, 1'b0);
        st4_chk(6, 3'd0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-HOLD
        rd_addr = 6'd0;
        start();
        press(7'b0000001, 3'd2);
        ticks(3);
        release_k();
        press(7'b0000010, 3'd2);
        ticks(2);
        chk("pre_rst", 7, 16'({track, recording, rd_octave, rd_note}),
            16'({7'd1, 1'b1, 3'd2, 3'd1}));
        chk("pre_rst4", 7, 16'({track4, recording4, overflow4}),
            16'({3'd1, 1'b1, 1'b0}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 8, 16'({track, recording, rd_octave, rd_note}), 16'd0);
        chk("async_rst4", 8, 16'({track4, recording4, overflow4}), 16'd0);
        en       = 1'b0;
        note_key = 7'd0;
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // metronome: silent while idle, every 4 ticks while recording
`ifdef REC_METRONOME_EN
        exp_rec = 3;
`else
        exp_rec = 0;
`endif
        click_window(8, c_idle);
        chk("click_idle", 9, 16'(c_idle), 16'd0);
        start();
        click_window(12, c_rec);
        chk("click_rec", 10, 16'(c_rec), 16'(exp_rec));
        en = 1'b0;
        cyc(3);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/song_recorder.md
Name: song_recorder

Overview:
- Record-mode counterpart to the song playback path. It captures live key presses (note, octave, held duration) and rests from the player, quantizes each duration to a length code against the current full-note period, and writes entries sequentially into an internal track RAM.
- A registered read port returns octave/note/length per index, plus a track count, in the same form the playback side consumes from the song store.

Parameters:
- DEPTH, 64, number of track entries (power of two).
- ADDR_W, 6, log2(DEPTH).
- DUR_W, 10, duration counter width in ticks; saturates at all-ones.
- REST_MIN, 2, minimum gap in ticks for a rest entry to be stored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  record mode enable (level).
- clr  in  1  clear track; honoured only while idle (en=0).
- tick  in  1  one-cycle timebase pulse; durations are counted in ticks.
- full_note  in  8  ticks per whole note; must be nonzero.
- note_key  in  7  one-hot note keys, bit i = note i+1; all-zero = released.
- octave  in  3  current octave, sampled at key press.
- rd_addr  in  ADDR_W  read index.
- rd_octave  out  3  registered read data.
- rd_note  out  3  registered read data; 0 = rest.
- rd_length  out  3  registered read data; length code.
- track  out  ADDR_W+1  number of valid entries.
- recording  out  1  high in ARMED/HOLD/GAP.
- full  out  1  track == DEPTH.
- overflow  out  1  sticky: a commit was dropped because the track was full.
- click  out  1  metronome pulse (optional feature).

Behaviour:
- Reset (async): state IDLE; track, full, overflow, recording, click and rd_* all 0; duration counter 0. RAM contents are not cleared.
- Key decode: note = index+1 of the lowest set bit of note_key. Multi-hot keys resolve to the lowest bit. Inputs arrive already synchronized.
- IDLE: en=1 goes to ARMED; track, full and overflow are kept. clr=1 with en=0 sets track=0, full=0, overflow=0.
- ARMED: waits for a press; leading silence is never recorded. A press goes to HOLD, capturing note and octave, with dur=0.
- HOLD: dur increments on each tick, saturating. Exit conditions:
  - Release: commit {octave, note, code(dur)} and go to GAP with dur=0.
  - A different nonzero note without a release: commit the old note, capture the new one, dur=0, stay in HOLD.
- GAP: dur counts ticks. On a press: if dur >= REST_MIN, commit the rest {0, 0, code(dur)}; otherwise discard it. Then go to HOLD with the new capture.
- en falls: from HOLD, commit the held note; from GAP, discard the trailing rest. Then go to IDLE. A press and a release in the same cycle as the en fall are ignored.
- Quantization: T_k = (3*full_note) >> (k+2), computed at 10-bit width.
  - code 0 if dur >= T_0; code 1 if dur >= T_1; code 2 if dur >= T_2; code 3 if dur >= T_3; otherwise code 4.
  - Example at full_note=16: thresholds are 12, 6, 3, 1.
- Commit: the RAM write at address track and the track+1 increment happen on the same edge that detects the event. No extra latency and no stall; the next capture happens on that same edge.
- Full: when track == DEPTH, a commit does not write and sets overflow. Recording continues counting. full = (track == DEPTH).
- Read: rd_* update one cycle after rd_addr. If rd_addr >= track, rd_* = 0. A read and a write to the same address on the same edge return the old RAM data.
- A tick coincident with a commit counts toward the new segment: dur starts at 1.

Optional Feature:
- Macro: REC_METRONOME_EN.
- Defined: a tick counter that wraps at max(full_note>>2, 1) runs while recording. click pulses for 1 cycle on each wrap, aligned to the wrapping tick. The counter resets on entering ARMED.
- Undefined: click is tied to 0 and there is no counter logic. The port list is unchanged.

Test Plan:
- full_note=16, en=1; press bit2 at octave 4 for 8 ticks, release, en=0 -> track=1; rd_addr=0 gives (4,3,1) one cycle later.
- Note1 held 4 ticks, gap of 5 ticks, note5 held 12 ticks, en=0 -> track=3; entries (o,1,2), (0,0,2), (o,5,0).
- Note1 held 4 ticks, gap of 1 tick (< REST_MIN), note2 held 1 tick, en=0 -> track=2 with no rest entry; second entry has length code 3.
- Note bit0 switched directly to bit3 without release -> two entries, notes 1 then 4; the second octave is sampled at the switch.
- DEPTH=4 override; record 5 notes -> track=4, full=1, overflow=1; entry 4 is not written; clr while idle -> track=0, full=0, overflow=0.
- Assert rst mid-HOLD -> outputs go to 0 immediately, without waiting for clk. With REC_METRONOME_EN and full_note=16: click every 4 ticks in ARMED/HOLD/GAP, and none in IDLE.
